// File: rtl/microseq_controller.sv
// Micro-program sequencer: owns the control-store address (upc), picks the next
// address from increment/jump/map/return stack, and runs an IDLE->RUN->DONE handshake.
module microseq_controller #(
  parameter int              ADDR_W      = 16,
  parameter int              JUMP_W      = 7,
  parameter logic [ADDR_W-1:0] START_ADDR = 16'd1,
  parameter int              STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic [2:0]        seq_op,
  input  logic [JUMP_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] map_addr,
  input  logic              z_flag,
  output logic [ADDR_W-1:0] upc,
  output logic [1:0]        nxt_sel,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = PTR_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_INC  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_MAP  = 3'd2;
  localparam logic [2:0] OP_BRZ  = 3'd3;
  localparam logic [2:0] OP_BRNZ = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RET  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [1:0] SEL_INC   = 2'd0;
  localparam logic [1:0] SEL_JMP   = 2'd1;
  localparam logic [1:0] SEL_MAP   = 2'd2;
  localparam logic [1:0] SEL_STACK = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] upc_nxt;
  logic [SP_W-1:0]   sp, sp_nxt;
  logic              err_nxt;
  logic              push;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic [ADDR_W-1:0] upc_inc;
  logic [ADDR_W-1:0] jump_ext;
  logic [PTR_W-1:0]  push_idx;
  logic [PTR_W-1:0]  top_idx;
  logic              stack_full;
  logic              stack_empty;

  assign upc_inc     = upc + ADDR_W'(1);
  assign jump_ext    = {{(ADDR_W-JUMP_W){1'b0}}, jump_addr};
  assign push_idx    = PTR_W'(sp);
  assign top_idx     = PTR_W'(sp - SP_W'(1));
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    upc_nxt   = upc;
    sp_nxt    = sp;
    err_nxt   = err;
    nxt_sel   = SEL_INC;
    push      = 1'b0;
    case (state)
      IDLE: begin
        upc_nxt = START_ADDR;
        if (start) begin
          state_nxt = RUN;
          err_nxt   = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          case (seq_op)
            OP_INC: upc_nxt = upc_inc;
            OP_JMP: begin
              upc_nxt = jump_ext;
              nxt_sel = SEL_JMP;
            end
            OP_MAP: begin
              upc_nxt = map_addr;
              nxt_sel = SEL_MAP;
            end
            OP_BRZ, OP_BRNZ: begin
              // BRZ takes the jump on z=1, BRNZ on z=0
              if (z_flag == (seq_op == OP_BRZ)) begin
                upc_nxt = jump_ext;
                nxt_sel = SEL_JMP;
              end else begin
                upc_nxt = upc_inc;
              end
            end
            OP_CALL: begin
              if (stack_full) begin
                err_nxt   = 1'b1;
                state_nxt = DONE;
              end else begin
                push    = 1'b1;
                sp_nxt  = sp + SP_W'(1);
                upc_nxt = jump_ext;
                nxt_sel = SEL_JMP;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                err_nxt   = 1'b1;
                state_nxt = DONE;
              end else begin
                sp_nxt  = sp - SP_W'(1);
                upc_nxt = stack[top_idx];
                nxt_sel = SEL_STACK;
              end
            end
            OP_HALT: state_nxt = DONE;
            default: state_nxt = DONE;
          endcase
        end
      end
      DONE: begin
        state_nxt = IDLE;
        upc_nxt   = START_ADDR;
      end
      default: begin
        state_nxt = IDLE;
        upc_nxt   = START_ADDR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      upc   <= START_ADDR;
      sp    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      upc   <= upc_nxt;
      sp    <= sp_nxt;
      err   <= err_nxt;
    end
  end

  // Stack contents are not reset; clearing sp is enough to discard them.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[push_idx] <= upc_inc;
    end
  end

endmodule
